// File: rtl/blackjack_game_ctrl_if.sv
// blackjack_game_ctrl_if: card request/valid and shuffle handshake between the game sequencer and the deck block.
interface blackjack_game_ctrl_if;
    logic       cardReq;
    logic       cardValid;
    logic [3:0] cardValue;
    logic       deckLow;
    logic       deckReady;
    logic       shuffleReq;
    modport master (output cardReq, shuffleReq, input cardValid, cardValue, deckLow, deckReady);
    modport slave  (input cardReq, shuffleReq, output cardValid, cardValue, deckLow, deckReady);
endinterface

// File: rtl/blackjack_game_ctrl.sv
// blackjack_game_ctrl: round sequencer that fetches cards, scores both hands and decides the outcome.
// Define DEALER_HITS_SOFT17_EN to make the dealer draw on a soft 17.
module blackjack_game_ctrl #(
    parameter int DEALER_STAND = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dealBtn_i,
    input  logic                  hitBtn_i,
    input  logic                  standBtn_i,
    blackjack_game_ctrl_if.master deck,
    output logic [2:0]            state_o,
    output logic [4:0]            playerHand_o,
    output logic [4:0]            dealerHand_o,
    output logic [1:0]            displayState_o,
    output logic                  resetToReshuffle_o
);
    typedef enum logic [2:0] {IDLE = 3'd0, DEAL = 3'd1, PLAYER_TURN = 3'd2, DEALER_TURN = 3'd3, END_GAME = 3'd4, LOAD = 3'd5} state_t;
    typedef enum logic [1:0] {LOSE = 2'd0, TIE = 2'd1, WIN = 2'd2, BJ = 2'd3} outcome_t;
    localparam logic [4:0] STAND = 5'(DEALER_STAND);

    state_t     state_q, state_d;
    outcome_t   disp_q, disp_d;
    logic [4:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d, d_first_q, d_first_d;
    logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
    logic [2:0] cnt_q, cnt_d;
    logic       req_q, req_d, shuf_q, shuf_d, resh_q, resh_d;
    logic [4:0] p_best, d_best, pts;
    logic       acc, to_player, d_draw, is_ace;

    assign p_best    = (p_ace_q && p_hard_q <= 5'd11) ? p_hard_q + 5'd10 : p_hard_q;
    assign d_best    = (d_ace_q && d_hard_q <= 5'd11) ? d_hard_q + 5'd10 : d_hard_q;
    assign pts       = (deck.cardValue > 4'd10) ? 5'd10 : {1'b0, deck.cardValue};
    assign is_ace    = deck.cardValue == 4'd1;
    assign acc       = req_q && deck.cardValid && deck.cardValue != 4'd0;
    assign to_player = state_q == PLAYER_TURN || (state_q == DEAL && !cnt_q[0]);
`ifdef DEALER_HITS_SOFT17_EN
    assign d_draw = d_best < STAND || (d_ace_q && d_hard_q == 5'd7);
`else
    assign d_draw = d_best < STAND;
`endif

    always_comb begin
        state_d   = state_q;
        disp_d    = disp_q;
        p_hard_d  = p_hard_q;
        p_ace_d   = p_ace_q;
        d_hard_d  = d_hard_q;
        d_ace_d   = d_ace_q;
        d_first_d = d_first_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        shuf_d    = 1'b0;
        resh_d    = resh_q;
        if (acc) begin
            req_d    = 1'b0;
            p_hard_d = to_player ? p_hard_q + pts : p_hard_q;
            p_ace_d  = p_ace_q | (to_player & is_ace);
            d_hard_d = to_player ? d_hard_q : d_hard_q + pts;
            d_ace_d  = d_ace_q | (!to_player & is_ace);
            cnt_d    = (state_q == DEAL) ? cnt_q + 3'd1 : cnt_q;
            if (state_q == DEAL && cnt_q == 3'd1) d_first_d = is_ace ? 5'd11 : pts;
        end
        // Every decision below is taken only while no fetch is outstanding, i.e. on the updated sums.
        case (state_q)
            IDLE: if (dealBtn_i) begin
                state_d = resh_q ? LOAD : DEAL;
                shuf_d  = resh_q;
            end
            LOAD: if (deck.deckReady) begin
                state_d = DEAL;
                resh_d  = 1'b0;
            end
            DEAL: if (!req_q) begin
                if (cnt_q != 3'd4) req_d = 1'b1;
                else if (p_best == 5'd21) begin
                    state_d = END_GAME;
                    disp_d  = (d_best == 5'd21) ? TIE : BJ;
                end else state_d = PLAYER_TURN;
            end
            PLAYER_TURN: if (!req_q) begin
                if (p_best > 5'd21) begin
                    state_d = END_GAME;
                    disp_d  = LOSE;
                end else if (p_best == 5'd21 || standBtn_i) state_d = DEALER_TURN;
                else if (hitBtn_i) req_d = 1'b1;
            end
            DEALER_TURN: if (!req_q) begin
                if (d_draw) req_d = 1'b1;
                else begin
                    state_d = END_GAME;
                    disp_d  = (d_best > 5'd21 || p_best > d_best) ? WIN : (p_best == d_best) ? TIE : LOSE;
                end
            end
            END_GAME: if (dealBtn_i) begin
                state_d = IDLE;
                resh_d  = resh_q | deck.deckLow;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DEAL && state_q != DEAL) begin
            p_hard_d  = 5'd0;
            p_ace_d   = 1'b0;
            d_hard_d  = 5'd0;
            d_ace_d   = 1'b0;
            d_first_d = 5'd0;
            cnt_d     = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            disp_q    <= LOSE;
            p_hard_q  <= 5'd0;
            p_ace_q   <= 1'b0;
            d_hard_q  <= 5'd0;
            d_ace_q   <= 1'b0;
            d_first_q <= 5'd0;
            cnt_q     <= 3'd0;
            req_q     <= 1'b0;
            shuf_q    <= 1'b0;
            resh_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            disp_q    <= disp_d;
            p_hard_q  <= p_hard_d;
            p_ace_q   <= p_ace_d;
            d_hard_q  <= d_hard_d;
            d_ace_q   <= d_ace_d;
            d_first_q <= d_first_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            shuf_q    <= shuf_d;
            resh_q    <= resh_d;
        end
    end

    assign deck.cardReq       = req_q;
    assign deck.shuffleReq    = shuf_q;
    assign state_o            = state_q;
    assign playerHand_o       = p_best;
    assign dealerHand_o       = (state_q == DEAL || state_q == PLAYER_TURN) ? d_first_q : d_best;
    assign displayState_o     = disp_q;
    assign resetToReshuffle_o = resh_q;
endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// tb_blackjack_game_ctrl: directed rounds; expected snapshots on every state change are queued and checked by a monitor.
module tb_blackjack_game_ctrl;
    logic       clk = 1'b0, rst = 1'b1, dealBtn = 1'b0, hitBtn = 1'b0, standBtn = 1'b0;
    logic [2:0] state;
    logic [4:0] playerHand, dealerHand;
    logic [1:0] displayState;
    logic       resetToReshuffle;
    int         n_chk = 0, n_fail = 0;
    logic [2:0] prev_state = 3'd0;
    logic [4:0] d4;
    logic [1:0] o4;

    typedef struct {string tag; logic [15:0] v;} exp_t;
    exp_t exp_q[$];

    blackjack_game_ctrl_if deck();

    blackjack_game_ctrl dut (
        .clk(clk), .rst(rst), .dealBtn_i(dealBtn), .hitBtn_i(hitBtn), .standBtn_i(standBtn),
        .deck(deck), .state_o(state), .playerHand_o(playerHand), .dealerHand_o(dealerHand),
        .displayState_o(displayState), .resetToReshuffle_o(resetToReshuffle)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (state != prev_state) begin
            exp_t e;
            logic [15:0] act;
            act = {state, playerHand, dealerHand, displayState, resetToReshuffle};
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_state_change: got st=%0d ph=%0d dh=%0d ds=%0d rs=%0d, required no change",
                         state, playerHand, dealerHand, displayState, resetToReshuffle);
            end else begin
                e = exp_q.pop_front();
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got st=%0d ph=%0d dh=%0d ds=%0d rs=%0d, required st=%0d ph=%0d dh=%0d ds=%0d rs=%0d",
                             e.tag, state, playerHand, dealerHand, displayState, resetToReshuffle,
                             e.v[15:13], e.v[12:8], e.v[7:3], e.v[2:1], e.v[0]);
                end
            end
            prev_state = state;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", tag, act, req);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic [4:0] ph, input logic [4:0] dh,
                            input logic [1:0] ds, input logic rs);
        exp_t e;
        e.tag = tag;
        e.v   = {st, ph, dh, ds, rs};
        exp_q.push_back(e);
    endtask

    // which: bit0 deal, bit1 hit, bit2 stand
    task automatic press(input logic [2:0] which);
        dealBtn  = which[0];
        hitBtn   = which[1];
        standBtn = which[2];
        tick();
        dealBtn  = 1'b0;
        hitBtn   = 1'b0;
        standBtn = 1'b0;
    endtask

    task automatic card(input logic [3:0] v);
        int n = 0;
        while (!deck.cardReq && n < 50) begin
            tick();
            n++;
        end
        if (!deck.cardReq) begin
            chk("card_req_rise", deck.cardReq, 1);
            return;
        end
        deck.cardValid = 1'b1;
        deck.cardValue = v;
        tick();
        deck.cardValid = 1'b0;
        deck.cardValue = 4'd0;
    endtask

    task automatic deal4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        card(a);
        card(b);
        card(c);
        card(d);
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state != s && n < 100) begin
            tick();
            n++;
        end
        chk("wait_state", state, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        deck.cardValid = 1'b0;
        deck.cardValue = 4'd0;
        deck.deckLow   = 1'b0;
        deck.deckReady = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_player", playerHand, 0);
        chk("rst_dealer", dealerHand, 0);
        chk("rst_disp", displayState, 0);
        chk("rst_reshuffle", resetToReshuffle, 1);
        chk("rst_cardreq", deck.cardReq, 0);
        chk("rst_shufflereq", deck.shuffleReq, 0);

        // first round always shuffles, then a player blackjack
        push_exp("to_load", 3'd5, 5'd0, 5'd0, 2'd0, 1'b1);
        press(3'b001);
        chk("shuffle_pulse_hi", deck.shuffleReq, 1);
        tick();
        chk("shuffle_pulse_lo", deck.shuffleReq, 0);
        chk("load_waits", state, 5);
        push_exp("load_to_deal", 3'd1, 5'd0, 5'd0, 2'd0, 1'b0);
        deck.deckReady = 1'b1;
        tick();
        deck.deckReady = 1'b0;
        chk("reshuffle_cleared", resetToReshuffle, 0);
        push_exp("blackjack", 3'd4, 5'd21, 5'd16, 2'd3, 1'b0);
        deal4(4'd1, 4'd9, 4'd13, 4'd7);
        wait_state(3'd4);

        // hit to bust, with an illegal card and a late card on the hit
        push_exp("r2_idle", 3'd0, 5'd21, 5'd16, 2'd3, 1'b0);
        press(3'b001);
        push_exp("r2_deal", 3'd1, 5'd0, 5'd0, 2'd3, 1'b0);
        press(3'b001);
        push_exp("r2_player", 3'd2, 5'd15, 5'd6, 2'd3, 1'b0);
        deal4(4'd10, 4'd6, 4'd5, 4'd2);
        wait_state(3'd2);
        push_exp("r2_bust", 3'd4, 5'd24, 5'd8, 2'd0, 1'b0);
        press(3'b010);
        chk("hit_req", deck.cardReq, 1);
        deck.cardValid = 1'b1;
        deck.cardValue = 4'd0;
        tick();
        deck.cardValid = 1'b0;
        chk("zero_card_req_held", deck.cardReq, 1);
        chk("zero_card_ignored", playerHand, 15);
        repeat (5) tick();
        chk("late_card_req_held", deck.cardReq, 1);
        chk("late_card_total", playerHand, 15);
        card(4'd9);
        chk("accept_req_low", deck.cardReq, 0);
        chk("accept_total", playerHand, 24);
        wait_state(3'd4);
        repeat (3) tick();
        chk("bust_no_dealer_draw", deck.cardReq, 0);

        // deck low forces a shuffle; dealer busts
        deck.deckLow = 1'b1;
        push_exp("r3_idle_low", 3'd0, 5'd24, 5'd8, 2'd0, 1'b1);
        press(3'b001);
        deck.deckLow = 1'b0;
        push_exp("r3_load", 3'd5, 5'd24, 5'd8, 2'd0, 1'b1);
        press(3'b001);
        push_exp("r3_deal", 3'd1, 5'd0, 5'd0, 2'd0, 1'b0);
        deck.deckReady = 1'b1;
        tick();
        deck.deckReady = 1'b0;
        push_exp("r3_player", 3'd2, 5'd18, 5'd10, 2'd0, 1'b0);
        deal4(4'd10, 4'd10, 4'd8, 4'd6);
        wait_state(3'd2);
        push_exp("r3_dealer", 3'd3, 5'd18, 5'd16, 2'd0, 1'b0);
        push_exp("r3_dealer_bust", 3'd4, 5'd18, 5'd26, 2'd2, 1'b0);
        press(3'b100);
        card(4'd10);
        wait_state(3'd4);

        // dealer soft 17
        push_exp("r4_idle", 3'd0, 5'd18, 5'd26, 2'd2, 1'b0);
        press(3'b001);
        push_exp("r4_deal", 3'd1, 5'd0, 5'd0, 2'd2, 1'b0);
        press(3'b001);
        push_exp("r4_player_ace_up", 3'd2, 5'd18, 5'd11, 2'd2, 1'b0);
        deal4(4'd10, 4'd1, 4'd8, 4'd6);
        wait_state(3'd2);
        push_exp("r4_dealer", 3'd3, 5'd18, 5'd17, 2'd2, 1'b0);
`ifdef DEALER_HITS_SOFT17_EN
        d4 = 5'd19;
        o4 = 2'd0;
        push_exp("r4_soft17_draw", 3'd4, 5'd18, 5'd19, 2'd0, 1'b0);
        press(3'b100);
        card(4'd2);
`else
        d4 = 5'd17;
        o4 = 2'd2;
        push_exp("r4_soft17_stand", 3'd4, 5'd18, 5'd17, 2'd2, 1'b0);
        press(3'b100);
`endif
        wait_state(3'd4);

        // both blackjack -> tie
        push_exp("r5_idle", 3'd0, 5'd18, d4, o4, 1'b0);
        press(3'b001);
        push_exp("r5_deal", 3'd1, 5'd0, 5'd0, o4, 1'b0);
        press(3'b001);
        push_exp("r5_bj_tie", 3'd4, 5'd21, 5'd21, 2'd1, 1'b0);
        deal4(4'd1, 4'd1, 4'd10, 4'd10);
        wait_state(3'd4);

        // hit to exactly 21 moves to the dealer automatically
        push_exp("r6_idle", 3'd0, 5'd21, 5'd21, 2'd1, 1'b0);
        press(3'b001);
        push_exp("r6_deal", 3'd1, 5'd0, 5'd0, 2'd1, 1'b0);
        press(3'b001);
        push_exp("r6_player", 3'd2, 5'd15, 5'd10, 2'd1, 1'b0);
        deal4(4'd10, 4'd10, 4'd5, 4'd7);
        wait_state(3'd2);
        push_exp("r6_auto_dealer", 3'd3, 5'd21, 5'd17, 2'd1, 1'b0);
        push_exp("r6_win", 3'd4, 5'd21, 5'd17, 2'd2, 1'b0);
        press(3'b010);
        card(4'd6);
        wait_state(3'd4);

        // hit and stand together: stand wins, dealer 18 beats 13
        push_exp("r7_idle", 3'd0, 5'd21, 5'd17, 2'd2, 1'b0);
        press(3'b001);
        push_exp("r7_deal", 3'd1, 5'd0, 5'd0, 2'd2, 1'b0);
        press(3'b001);
        push_exp("r7_player", 3'd2, 5'd13, 5'd9, 2'd2, 1'b0);
        deal4(4'd10, 4'd9, 4'd3, 4'd9);
        wait_state(3'd2);
        push_exp("r7_stand_wins", 3'd3, 5'd13, 5'd18, 2'd2, 1'b0);
        push_exp("r7_lose", 3'd4, 5'd13, 5'd18, 2'd0, 1'b0);
        press(3'b110);
        wait_state(3'd4);

        // reset in the middle of a fetch
        push_exp("r8_idle", 3'd0, 5'd13, 5'd18, 2'd0, 1'b0);
        press(3'b001);
        push_exp("r8_deal", 3'd1, 5'd0, 5'd0, 2'd0, 1'b0);
        press(3'b001);
        for (int i = 0; i < 10 && !deck.cardReq; i++) tick();
        chk("r8_req_before_rst", deck.cardReq, 1);
        #3;
        deck.cardValid = 1'b1;
        deck.cardValue = 4'd5;
        push_exp("r8_async_rst", 3'd0, 5'd0, 5'd0, 2'd0, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_cardreq", deck.cardReq, 0);
        repeat (2) tick();
        rst = 1'b0;
        deck.cardValid = 1'b0;
        deck.cardValue = 4'd0;
        tick();
        chk("rst_card_discarded", playerHand, 0);
        chk("rst_reshuffle_again", resetToReshuffle, 1);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
